// File: rtl/ucie_sb_pkg.sv
// Shared sideband constants and types for the UCIe sideband transmit path.
// Default packet width and minimum inter-packet idle time in UI.
package ucie_sb_pkg;

  localparam int SB_PKT_W      = 64;
  localparam int SB_MIN_GAP_UI = 32;

  typedef enum logic [1:0] {
    SB_TX_IDLE,
    SB_TX_SEND,
    SB_TX_GAP
  } sb_tx_state_e;

  typedef logic [SB_PKT_W-1:0] sb_pkt_t;

endpackage

// File: rtl/ucie_sb_tx_serializer.sv
// Sideband TX serializer: one packet per valid/ready accept, LSB-first, two clk cycles per UI.
// Outputs registered; pkt_ready only in IDLE, so the source simply holds pkt_valid during SEND/GAP.
module ucie_sb_tx_serializer
  import ucie_sb_pkg::*;
#(
  parameter int PKT_W      = SB_PKT_W,
  parameter int MIN_GAP_UI = SB_MIN_GAP_UI
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  input  logic [PKT_W-1:0] pkt_data,
  output logic             pkt_ready,
  output logic             SBTX_CLK,
  output logic             SBTX_DATA,
  output logic             busy,
  output logic             pkt_sent
);

  localparam int BIT_W = $clog2(PKT_W);
  localparam int GAP_W = $clog2(2 * MIN_GAP_UI);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PKT_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(2 * MIN_GAP_UI - 1);

  localparam logic [1:0] ST_IDLE = SB_TX_IDLE;
  localparam logic [1:0] ST_SEND = SB_TX_SEND;
  localparam logic [1:0] ST_GAP  = SB_TX_GAP;

  logic [1:0]       state_q,   state_d;
  logic [PKT_W-1:0] shreg_q,   shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             phase_q,   phase_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             sbclk_q,   sbclk_d;
  logic             sbdat_q,   sbdat_d;
  logic             sent_q,    sent_d;
  logic             rst_rel_q;

  // Ready comes from registers only, so it stays low until the first edge after release.
  assign pkt_ready = (state_q == ST_IDLE) && rst_rel_q;
  assign busy      = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign SBTX_CLK  = sbclk_q;
  assign SBTX_DATA = sbdat_q;
  assign pkt_sent  = sent_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    gap_cnt_d = gap_cnt_q;
    sbclk_d   = 1'b0;
    sbdat_d   = 1'b0;
    sent_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pkt_valid && pkt_ready) begin
          shreg_d   = pkt_data;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          sbdat_d = shreg_q[0];
        end else begin
          // Forwarded clock rises mid-UI; data was launched one clk earlier.
          sbclk_d = 1'b1;
          sbdat_d = sbdat_q;
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            sent_d    = 1'b1;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
        phase_d   = 1'b0;
        gap_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      gap_cnt_q <= '0;
      sbclk_q   <= 1'b0;
      sbdat_q   <= 1'b0;
      sent_q    <= 1'b0;
      rst_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      gap_cnt_q <= gap_cnt_d;
      sbclk_q   <= sbclk_d;
      sbdat_q   <= sbdat_d;
      sent_q    <= sent_d;
      rst_rel_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucie_sb_tx_serializer.sv
// Directed bench for ucie_sb_tx_serializer: default 64-bit instance plus a PKT_W=32 / MIN_GAP_UI=40 instance.
`timescale 1ns/1ps
module tb_ucie_sb_tx_serializer;
  import ucie_sb_pkg::*;

  logic clk = 1'b0;
  always #1 clk = ~clk;

  logic        reset;
  logic        pkt_valid;
  sb_pkt_t     pkt_data;
  logic        pkt_ready, SBTX_CLK, SBTX_DATA, busy, pkt_sent;

  logic        pkt_valid2;
  logic [31:0] pkt_data2;
  logic        pkt_ready2, sbclk2, sbdat2, busy2, sent2;

  ucie_sb_tx_serializer u_dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .SBTX_CLK(SBTX_CLK), .SBTX_DATA(SBTX_DATA),
    .busy(busy), .pkt_sent(pkt_sent)
  );

  ucie_sb_tx_serializer #(.PKT_W(32), .MIN_GAP_UI(40)) u_dut32 (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid2), .pkt_data(pkt_data2),
    .pkt_ready(pkt_ready2), .SBTX_CLK(sbclk2), .SBTX_DATA(sbdat2),
    .busy(busy2), .pkt_sent(sent2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitors, sampled on the falling edge.
  int   rise_cyc[$];
  logic rise_bit[$];
  int   sent_cyc[$];
  int   rise_cyc2[$];
  logic rise_bit2[$];
  int   sent_cyc2[$];
  int   gap_viol  = 0;
  int   busy_cyc  = 0;
  int   last_sent = -1000;
  logic clk_prev  = 1'b0;
  logic clk_prev2 = 1'b0;

  always @(negedge clk) begin
    if (SBTX_CLK && !clk_prev) begin
      rise_cyc.push_back(cyc);
      rise_bit.push_back(SBTX_DATA);
    end
    clk_prev = SBTX_CLK;
    if (pkt_sent) begin
      sent_cyc.push_back(cyc);
      last_sent = cyc;
    end else if (cyc > last_sent && cyc <= last_sent + 2*SB_MIN_GAP_UI + 1 && (SBTX_CLK || SBTX_DATA)) begin
      gap_viol++;
    end
    if (busy) busy_cyc++;
    if (sbclk2 && !clk_prev2) begin
      rise_cyc2.push_back(cyc);
      rise_bit2.push_back(sbdat2);
    end
    clk_prev2 = sbclk2;
    if (sent2) sent_cyc2.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #0.2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Offer a packet; acc is the index of the posedge that accepts it.
  task automatic send(input logic [63:0] d, input bit hold, output int acc);
    int t;
    t = 0;
    pkt_valid = 1'b1;
    pkt_data  = d;
    while (!pkt_ready && t < 1000) begin step(); t++; end
    if (t >= 1000) check_eq("ready_timeout", 64'd0, 64'd1);
    acc = cyc + 1;
    step();
    if (!hold) pkt_valid = 1'b0;
  endtask

  task automatic send2(input logic [31:0] d, input bit hold, output int acc);
    int t;
    t = 0;
    pkt_valid2 = 1'b1;
    pkt_data2  = d;
    while (!pkt_ready2 && t < 1000) begin step(); t++; end
    if (t >= 1000) check_eq("ready2_timeout", 64'd0, 64'd1);
    acc = cyc + 1;
    step();
    if (!hold) pkt_valid2 = 1'b0;
  endtask

  function automatic logic [63:0] word_from(input bit sel, input int base, input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (!sel && base + k < rise_bit.size())  w[k] = rise_bit[base + k];
      if (sel  && base + k < rise_bit2.size()) w[k] = rise_bit2[base + k];
    end
    return w;
  endfunction

  function automatic int spacing_errs(input int base, input int n);
    int e;
    e = 0;
    for (int k = 1; k < n; k++)
      if (base + k >= rise_cyc.size() || rise_cyc[base + k] - rise_cyc[base + k - 1] != 2) e++;
    return e;
  endfunction

  initial begin
    int a, a2, b, sb, gv, bc, rc, t;
    reset      = 1'b0;
    pkt_valid  = 1'b0;
    pkt_data   = '0;
    pkt_valid2 = 1'b0;
    pkt_data2  = '0;

    // Reset state
    wait_cycles(3);
    check_eq("rst_sbclk", 64'(SBTX_CLK), 64'd0);
    check_eq("rst_sbdata", 64'(SBTX_DATA), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_sent", 64'(pkt_sent), 64'd0);
    check_eq("rst_ready", 64'(pkt_ready), 64'd0);
    reset = 1'b1;
    step();
    check_eq("ready_after_release", 64'(pkt_ready), 64'd1);

    // Single packet
    b = rise_cyc.size(); sb = sent_cyc.size();
    send(64'hA5A5_0000_FFFF_1234, 1'b0, a);
    wait_cycles(135);
    check_eq("p1_rises", 64'(rise_cyc.size() - b), 64'd64);
    check_eq("p1_first_rise", 64'(rise_cyc[b] - a), 64'd2);
    check_eq("p1_spacing", 64'(spacing_errs(b, 64)), 64'd0);
    check_eq("p1_data", word_from(1'b0, b, 64), 64'hA5A5_0000_FFFF_1234);
    check_eq("p1_sent_cnt", 64'(sent_cyc.size() - sb), 64'd1);
    check_eq("p1_sent_cyc", 64'(sent_cyc[sb] - a), 64'd128);

    // Back-to-back with valid held
    t = 0;
    while (!pkt_ready && t < 200) begin step(); t++; end
    b = rise_cyc.size(); gv = gap_viol;
    send(64'h1, 1'b1, a);
    send(64'h8000_0000_0000_0000, 1'b0, a2);
    wait_cycles(135);
    check_eq("b2b_accept_gap", 64'(a2 - a), 64'd193);
    check_eq("b2b_rises", 64'(rise_cyc.size() - b), 64'd128);
    check_eq("b2b_rise_gap", 64'(rise_cyc[b + 64] - rise_cyc[b + 63]), 64'd67);
    check_eq("b2b_lines_low", 64'(gap_viol - gv), 64'd0);
    check_eq("b2b_data0", word_from(1'b0, b, 64), 64'h1);
    check_eq("b2b_data1", word_from(1'b0, b + 64, 64), 64'h8000_0000_0000_0000);

    // Data must be captured only at accept
    b = rise_cyc.size();
    send(64'hDEAD_BEEF_CAFE_F00D, 1'b0, a);
    repeat (135) begin
      pkt_data = {$urandom, $urandom};
      step();
    end
    check_eq("hold_data", word_from(1'b0, b, 64), 64'hDEAD_BEEF_CAFE_F00D);

    // Asynchronous reset at bit 20
    b = rise_cyc.size();
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, a);
    t = 0;
    while (rise_cyc.size() - b < 21 && t < 200) begin step(); t++; end
    check_eq("mid_pre_sbclk", 64'(SBTX_CLK), 64'd1);
    reset = 1'b0;
    #0.1;
    check_eq("mid_sbclk", 64'(SBTX_CLK), 64'd0);
    check_eq("mid_sbdata", 64'(SBTX_DATA), 64'd0);
    check_eq("mid_busy", 64'(busy), 64'd0);
    wait_cycles(3);
    reset = 1'b1;
    step();
    b = rise_cyc.size();
    send(64'h0F0F, 1'b0, a);
    wait_cycles(132);
    check_eq("post_rst_first_rise", 64'(rise_cyc[b] - a), 64'd2);
    check_eq("post_rst_data", word_from(1'b0, b, 64), 64'h0F0F);

    // Idle stall then single-cycle valid
    t = 0;
    while (!pkt_ready && t < 200) begin step(); t++; end
    bc = busy_cyc; rc = rise_cyc.size();
    wait_cycles(500);
    check_eq("stall_rises", 64'(rise_cyc.size() - rc), 64'd0);
    check_eq("stall_busy", 64'(busy_cyc - bc), 64'd0);
    b = rise_cyc.size();
    send(64'h3, 1'b0, a);
    check_eq("stall_accept", 64'(busy), 64'd1);
    wait_cycles(132);
    check_eq("stall_data", word_from(1'b0, b, 64), 64'h3);

    // Narrow instance: PKT_W=32, MIN_GAP_UI=40
    b = rise_cyc2.size(); sb = sent_cyc2.size();
    send2(32'hC3A5_0F01, 1'b1, a);
    send2(32'h1234_5678, 1'b0, a2);
    wait_cycles(70);
    check_eq("w32_accept_gap", 64'(a2 - a), 64'd145);
    check_eq("w32_sent_cyc", 64'(sent_cyc2[sb] - a), 64'd64);
    check_eq("w32_rises", 64'(rise_cyc2.size() - b), 64'd64);
    check_eq("w32_data0", word_from(1'b1, b, 32), 64'hC3A5_0F01);
    check_eq("w32_data1", word_from(1'b1, b + 32, 32), 64'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucie_sb_tx_serializer.md
Name: ucie_sb_tx_serializer

Overview:
Transmit-side sideband PHY serializer that drives SBTX_CLK/SBTX_DATA of ucie_sb_interface.
- Accepts one 64-bit sideband packet over a valid/ready handshake.
- Shifts it out LSB-first with a gated, source-synchronous forwarded clock (one pulse per UI).
- Holds both lines low for at least MIN_GAP_UI UI before the next packet.
- Runs on a 2x UI clock: clk = 1.6 GHz gives an 800 MHz SBTX_CLK.

Parameters:
PKT_W, 64, serialized packet width in bits
MIN_GAP_UI, 32, minimum idle UI between packets (one UI = 2 clk cycles)

Ports:
clk  input  1  2x UI clock (1.6 GHz nominal)
reset  input  1  asynchronous, active-low reset
pkt_valid  input  1  packet available on pkt_data
pkt_data  input  PKT_W  packet to transmit; bit 0 goes first
pkt_ready  output  1  block can accept a packet this cycle
SBTX_CLK  output  1  forwarded sideband clock, gated
SBTX_DATA  output  1  serial sideband data
busy  output  1  high in SEND or GAP
pkt_sent  output  1  one-cycle pulse on the last clk cycle of the last bit

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; shift register, bit_cnt, phase and gap_cnt cleared.
  - SBTX_CLK=0, SBTX_DATA=0, busy=0, pkt_sent=0.
  - pkt_ready=0 while reset is asserted.
- Output timing:
  - SBTX_CLK and SBTX_DATA are registered; no combinational path from inputs.
  - pkt_ready is decoded from the state register only: pkt_ready = (state==IDLE) && reset released.
- IDLE:
  - SBTX_CLK=0, SBTX_DATA=0.
  - On pkt_valid && pkt_ready at edge N: load shreg=pkt_data, bit_cnt=0, phase=0, go to SEND.
  - pkt_data is sampled only at the accept edge; later changes are ignored.
- SEND: phase toggles every clk.
  - phase 0 (edge N+1 for bit 0): SBTX_DATA=shreg[0], SBTX_CLK=0.
  - phase 1 (next edge): SBTX_CLK=1, SBTX_DATA held. The rising edge falls mid-UI, so data is stable for a full clk cycle on each side.
  - At the end of phase 1: shreg shifts right and bit_cnt increments.
  - On phase 1 of bit PKT_W-1: pkt_sent=1 for that cycle. Next edge goes to GAP with SBTX_CLK=0, SBTX_DATA=0, gap_cnt=0.
  - Packet occupies exactly 2*PKT_W = 128 clk cycles and produces 64 SBTX_CLK rising edges at a 2-cycle period.
- GAP:
  - SBTX_CLK=0, SBTX_DATA=0, pkt_ready=0.
  - gap_cnt counts to 2*MIN_GAP_UI-1 = 63, then goes to IDLE.
  - Minimum spacing from the last SBTX_CLK rise to the first rise of the next packet is 2*MIN_GAP_UI+3 clk cycles (≥ 40 ns at 1.6 GHz).
- Handshake:
  - pkt_valid while not ready is simply held by the source.
  - No drop or overwrite is possible; a single-entry skid buffer is not required.
- Counter widths:
  - bit_cnt is $clog2(PKT_W) bits and never wraps mid-packet.
  - gap_cnt is $clog2(2*MIN_GAP_UI) bits.
- Reset mid-SEND or mid-GAP: lines drop to 0 immediately and the partial packet is discarded. After release, the first accept starts a fresh packet; no gap is enforced after reset.
- Illegal state encoding: recover to IDLE with outputs low.

Decomposition:
- Package ucie_sb_pkg holds:
  - SB_PKT_W=64 and SB_MIN_GAP_UI=32 constants.
  - typedef enum logic [1:0] {SB_TX_IDLE, SB_TX_SEND, SB_TX_GAP} sb_tx_state_e.
  - typedef logic [SB_PKT_W-1:0] sb_pkt_t.
- A single flat module; no sub-module is warranted.
- The bench binds ucie_sb_interface assertions (800 MHz period, 32-UI gap, reset-clears) to the outputs.

Test Plan:
- Reset then single packet 64'hA5A5_0000_FFFF_1234: pkt_ready rises after release. SBTX_DATA bit k is valid on the SBTX_CLK rising edge k (k=0..63, LSB-first). 64 rising edges occur 2 cycles apart. pkt_sent pulses once on cycle 128 after accept.
- Back-to-back: pkt_valid held high with 64'h1 then 64'h8000_0000_0000_0000. Second accept occurs exactly 2*PKT_W+2*MIN_GAP_UI+1 = 193 cycles after the first. The 32-UI gap assertion passes, with SBTX_CLK/SBTX_DATA low throughout the gap.
- Data-hold: pkt_data changes every cycle after acceptance of 64'hDEAD_BEEF_CAFE_F00D. The serialized stream still equals 64'hDEAD_BEEF_CAFE_F00D.
- Reset asserted at bit 20 of a packet: SBTX_CLK=0, SBTX_DATA=0 and busy=0 immediately (asynchronous). After release, the next packet 64'h0F0F starts cleanly with bit 0 first.
- Stall: pkt_valid=0 for 500 cycles in IDLE. No SBTX_CLK edges occur and busy=0. pkt_valid is then asserted for 1 cycle with 64'h3; it is accepted on that cycle and transmitted as bit0=1, bit1=1, rest 0.
- Parameter sweep: PKT_W=32, MIN_GAP_UI=40. Packet is 64 cycles, gap is 80 cycles, and pkt_sent pulses after 64 cycles.
